// File: rtl/logic_gate_pkg.sv
// Shared types for the logic gate unit: operation codes, FSM states and
// the opcode width.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  function automatic int op_width();
    return OP_W;
  endfunction

endpackage

// File: rtl/logic_gate_unit_if.sv
// Operand/result handshake bundle of the logic gate unit.
interface logic_gate_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic_gate_pkg::op_e   in_op;
  logic                  in_mode;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_y;
  logic                  out_zero;
  logic                  out_ones;
  logic [CNT_W-1:0]      out_beats;

  modport master (
    output in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_ones, out_beats
  );

endinterface

// File: rtl/logic_gate_alu.sv
// Combinational bitwise operator shared by pairwise beats and frame folding.
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] y_o
);

  // Operation select
  always_comb begin
    y_o = {WIDTH{1'b0}};
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_ANDN: y_o = a_i & ~b_i;
      OP_PASS: y_o = a_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered, flow-controlled bitwise logic unit with pairwise and
// frame-accumulate modes.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_y_s;
  op_e              alu_op_s;

  assign in_ready_s = !valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Open frames fold the next operand into acc using the latched op
  always_comb begin
    alu_a_s  = bus.in_a;
    alu_b_s  = bus.in_b;
    alu_op_s = bus.in_op;
    if (state_q == ST_ACC) begin
      alu_a_s  = acc_q;
      alu_b_s  = bus.in_a;
      alu_op_s = op_q;
    end else begin
      alu_a_s  = bus.in_a;
      alu_b_s  = bus.in_b;
      alu_op_s = bus.in_op;
    end
  end

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i  (alu_a_s),
    .b_i  (alu_b_s),
    .op_i (alu_op_s),
    .y_o  (alu_y_s)
  );

  // Next-state, accumulator and result-load logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    y_d     = y_q;
    beats_d = beats_q;
    valid_d = valid_q && !bus.out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !bus.in_mode) begin
          y_d     = alu_y_s;
          beats_d = CNT_ONE;
          valid_d = 1'b1;
        end else if (accept_s) begin
          op_d  = bus.in_op;
          acc_d = alu_y_s;
          cnt_d = CNT_ONE;
          if (bus.in_last) begin
            y_d     = alu_y_s;
            beats_d = CNT_ONE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (accept_s) begin
          acc_d = alu_y_s;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          if (bus.in_last) begin
            y_d     = alu_y_s;
            beats_d = cnt_d;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (y_d == {WIDTH{1'b0}});
    ones_d = (y_d == {WIDTH{1'b1}});
  end

  // State, frame and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= OP_AND;
      y_q     <= {WIDTH{1'b0}};
      beats_q <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      ones_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      y_q     <= y_d;
      beats_q <= beats_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_q;
  assign bus.out_y     = y_q;
  assign bus.out_beats = beats_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ones  = ones_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: directed scenarios plus random traffic
// checked against a frame-level reference model.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   rand_rdy = 0;

  typedef struct {
    logic [7:0] y;
    int         beats;
  } exp_t;
  exp_t exp_q[$];

  // reference frame state
  bit         f_open = 0;
  logic [2:0] f_op;
  logic [7:0] f_acc;
  int         f_cnt;

  logic_gate_unit_if #(.WIDTH(8), .CNT_W(8)) bus ();
  logic_gate_unit_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  logic_gate_unit #(.WIDTH(8), .CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic_gate_unit #(.WIDTH(8), .CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic void push_exp(input logic [7:0] y, input int beats);
    exp_t e;
    e.y = y;
    e.beats = beats;
    exp_q.push_back(e);
  endfunction

  function automatic void model_accept(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input bit mode, input bit last);
    if (!f_open) begin
      if (!mode) begin
        push_exp(ref_op(op, a, b), 1);
      end else begin
        f_op  = op;
        f_acc = ref_op(op, a, b);
        f_cnt = 1;
        if (last) push_exp(f_acc, 1);
        else f_open = 1;
      end
    end else begin
      f_acc = ref_op(f_op, f_acc, a);
      if (f_cnt < 255) f_cnt++;
      if (last) begin
        push_exp(f_acc, f_cnt);
        f_open = 0;
      end
    end
  endfunction

  // Offers one beat and waits (bounded) for it to be accepted
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input bit mode, input bit last);
    bit ok;
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op_e'(op);
    bus.in_mode  = mode;
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      if (ok) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (ok) model_accept(a, b, op, mode, last);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every completed output transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {24'd0, bus.out_y}, 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_y",     {24'd0, bus.out_y},     {24'd0, e.y});
        check("sb_beats", {24'd0, bus.out_beats}, e.beats);
        check("sb_zero",  {31'd0, bus.out_zero},  {31'd0, (e.y == 8'h00)});
        check("sb_ones",  {31'd0, bus.out_ones},  {31'd0, (e.y == 8'hFF)});
      end
    end
  end

  initial begin
    logic [7:0] ya;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_op = OP_AND;
    bus.in_mode = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = 8'h00; bus2.in_b = 8'h00; bus2.in_op = OP_AND;
    bus2.in_mode = 1'b0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
    #22;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_y",     {24'd0, bus.out_y},     32'd0);
    check("rst_beats", {24'd0, bus.out_beats}, 32'd0);
    check("rst_zero",  {31'd0, bus.out_zero},  32'd1);
    check("rst_ones",  {31'd0, bus.out_ones},  32'd0);
    check("rst_ready", {31'd0, bus.in_ready},  32'd1);
    rst_n = 1'b1;
    idle(2);

    // pairwise
    send_beat(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
    check("pw_valid", {31'd0, bus.out_valid}, 32'd1);
    check("pw_y",     {24'd0, bus.out_y},     32'h30);
    send_beat(8'hF0, 8'h0F, 3'd4, 1'b0, 1'b0);
    check("pw_nor_zero", {31'd0, bus.out_zero}, 32'd1);

    // accumulate XOR frame
    send_beat(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
    check("acc_b1_novalid", {31'd0, bus.out_valid}, 32'd0);
    send_beat(8'h04, 8'h00, 3'd2, 1'b1, 1'b0);
    check("acc_b2_novalid", {31'd0, bus.out_valid}, 32'd0);
    send_beat(8'h08, 8'h00, 3'd2, 1'b1, 1'b1);
    check("acc_valid", {31'd0, bus.out_valid}, 32'd1);
    check("acc_y",     {24'd0, bus.out_y},     32'h0F);
    check("acc_beats", {24'd0, bus.out_beats}, 32'd3);

    // op latch: OR held although beat 2 offers AND
    send_beat(8'h0F, 8'h30, 3'd1, 1'b1, 1'b0);
    send_beat(8'hC0, 8'h00, 3'd0, 1'b1, 1'b1);
    check("latch_y",    {24'd0, bus.out_y},    32'hFF);
    check("latch_ones", {31'd0, bus.out_ones}, 32'd1);
    send_beat(8'hAA, 8'h0F, 3'd6, 1'b1, 1'b1);
    check("andn_y", {24'd0, bus.out_y}, 32'hA0);
    idle(2);

    // backpressure
    bus.out_ready = 1'b0;
    send_beat(8'h5A, 8'h0F, 3'd2, 1'b0, 1'b0);
    ya = 8'h55;
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_op = OP_OR; bus.in_mode = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("bp_y_stable",  {24'd0, bus.out_y},    {24'd0, ya});
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_beat(8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
    check("bp_next_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_next_y",     {24'd0, bus.out_y},     32'h36);
    idle(2);

    // reset mid-frame
    send_beat(8'h01, 8'h02, 3'd1, 1'b1, 1'b0);
    send_beat(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    f_open = 0;
    check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_y",     {24'd0, bus.out_y},     32'd0);
    check("mrst_beats", {24'd0, bus.out_beats}, 32'd0);
    check("mrst_ready", {31'd0, bus.in_ready},  32'd1);
    #4;
    rst_n = 1'b1;
    idle(1);
    send_beat(8'h11, 8'h22, 3'd2, 1'b1, 1'b1);
    check("post_rst_y",     {24'd0, bus.out_y},     32'h33);
    check("post_rst_beats", {24'd0, bus.out_beats}, 32'd1);
    idle(2);

    // saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_a = 8'hFF; bus2.in_b = 8'hFF;
      bus2.in_op = OP_AND; bus2.in_mode = 1'b1; bus2.in_last = (i == 4);
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    check("sat_valid", {31'd0, bus2.out_valid}, 32'd1);
    check("sat_y",     {24'd0, bus2.out_y},     32'hFF);
    check("sat_beats", {30'd0, bus2.out_beats}, 32'd3);

    // random traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send_beat(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    if (f_open) send_beat(8'($urandom), 8'h00, 3'd0, 1'b1, 1'b1);
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    idle(5);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered successor to the team's two-input gate primitives. It applies a selectable bitwise logic operation (AND/OR/XOR/NAND/NOR/XNOR/ANDN/PASS) to WIDTH-bit operands behind a valid/ready handshake. In pairwise mode each accepted beat produces one result. In accumulate mode a multi-beat frame is folded into one result emitted on the last beat. It sits between operand producers and downstream datapath stages that need registered, flow-controlled logic results.

## Interface
- WIDTH, 8, operand/result bit width (≥1)
- CNT_W, 8, width of beat counter (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (first beat of frame / pairwise only)
- in_op  in  3  operation code (package enum)
- in_mode  in  1  0 = pairwise, 1 = accumulate
- in_last  in  1  final beat of accumulate frame; ignored in pairwise
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  WIDTH  result
- out_zero  out  1  out_y == 0
- out_ones  out  1  out_y == all ones
- out_beats  out  CNT_W  beats folded into result, saturating

## Operation
- Op codes: 0 AND a&b, 1 OR, 2 XOR, 3 NAND ~(a&b), 4 NOR, 5 XNOR, 6 ANDN a&~b, 7 PASS_A (returns a).
- in_ready = !out_valid || out_ready, combinational, in both states.
- FSM states:
  - IDLE: no frame open.
  - ACC: accumulate frame open.
- IDLE, accepted beat with in_mode=0:
  - out_y ← op(in_a, in_b), out_beats ← 1, out_valid ← 1.
  - Stay in IDLE.
- IDLE, accepted beat with in_mode=1:
  - Latch in_op into op_q.
  - acc ← op(in_a, in_b), cnt ← 1.
  - If in_last: emit acc and cnt as the result, stay in IDLE. Otherwise go to ACC.
- ACC, accepted beat:
  - acc ← op_q(acc, in_a). in_b, in_op and in_mode are ignored.
  - cnt ← cnt+1, saturating at 2^CNT_W−1.
  - If in_last: emit the new acc/cnt and go to IDLE.
- Non-last accumulate beats do not touch out_valid/out_y.
- out_zero and out_ones are derived from the registered out_y.
- out_valid clears on out_ready when no new result is loaded that cycle. A simultaneous accept plus result load keeps out_valid=1 with the new data.

## Timing
- Latency: result visible the cycle after the accepting edge (the last beat for frames).
- Throughput: 1 beat/cycle while out_ready=1.
- While out_valid && !out_ready:
  - in_ready=0.
  - out_y, out_beats and the flags are held stable.
  - Accumulation pauses; no beats are dropped.
- Reset (async assert, any state, including mid-frame):
  - state=IDLE.
  - out_valid=0, out_y=0, out_beats=0, acc=0, cnt=0, op_q=0.
  - out_zero=1, out_ones=0 (out_ones=1 only if WIDTH... never, since out_y=0).
  - in_ready=1 immediately.
- After deassertion, the first accepted beat starts a new frame. A partial frame is discarded.
- in_valid with in_ready=0: no state change.

## Structure
- Package logic_gate_pkg holds:
  - the 3-bit op enum type and its eight encodings;
  - the state enum (IDLE, ACC);
  - a function or constant for the opcode width.
- Sub-module logic_gate_alu: purely combinational, parameter WIDTH; inputs a, b, op; output y.
  - Instanced once.
  - Operand A is muxed between in_a (IDLE) and acc (ACC).
  - Operand B is muxed between in_b (IDLE) and in_a (ACC).
  - The op is muxed between in_op (IDLE) and op_q (ACC).
- Top holds the FSM, acc/cnt/op_q registers, output register and handshake.

## Test plan
- Pairwise, WIDTH=8: a=0xF0, b=0x3C, op=AND → next cycle out_valid=1, out_y=0x30, out_beats=1, out_zero=0. Then op=NOR, a=0xF0, b=0x0F → out_y=0x00, out_zero=1.
- Accumulate XOR frame: the sequence below → one result, out_y=0x0F, out_beats=3. out_valid stays 0 until the cycle after beat 3.
  - Beat 1: a=0x01, b=0x02.
  - Beat 2: a=0x04.
  - Beat 3: a=0x08, last=1.
- Op latch: frame with the beats below → out_y=0xFF, out_ones=1 (OR applied throughout). A single-beat frame with a=0xAA, b=0x0F, op=ANDN, last=1 → out_y=0xA0, out_beats=1.
  - Beat 1: op=OR, a=0x0F, b=0x30.
  - Beat 2: op=AND, a=0xC0, last=1.
- Backpressure: hold out_ready=0 with a result pending → in_ready=0, out_y stable for 5 cycles, an offered beat is not consumed. Raise out_ready → that same cycle the beat is accepted, and the new result appears next cycle with no bubble.
- Reset mid-frame: after 2 beats of an OR frame, pulse rst_n low asynchronously → out_valid=0, out_y=0, out_beats=0 immediately. A following beat with a=0x11, b=0x22, op=XOR, mode=1, last=1 → out_y=0x33, out_beats=1.
- Saturation, CNT_W=2: 5-beat AND frame of 0xFF beats → out_y=0xFF, out_beats=3.
